// File: rtl/galaga_pkg.sv
// Shared types and default constants for the galaga game-logic stage.
package galaga_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_t;

  localparam int LIVES_DEF      = 3;
  localparam int HITMIN_DEF     = 4;
  localparam int HIT_FRAMES_DEF = 60;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/collision_monitor_if.sv
// Video-path bundle between the pixel generator / VGA controller and the collision monitor.
interface collision_monitor_if;
  import galaga_pkg::*;

  logic        vsync;
  logic        blank_b;
  logic        rpixel;
  logic        apixel;
  logic        start;
  game_state_t state;
  logic [2:0]  lives;
  logic [15:0] score;
  logic        freeze;
  logic        flash;
  logic        hit;

  // No handshake here: inputs are sampled every vgaclk cycle and outputs are
  // level values, except hit which is a single-cycle pulse.
  modport master (
    output vsync, blank_b, rpixel, apixel, start,
    input  state, lives, score, freeze, flash, hit
  );

  modport slave (
    input  vsync, blank_b, rpixel, apixel, start,
    output state, lives, score, freeze, flash, hit
  );
endinterface

// File: rtl/collision_monitor_overlap_counter.sv
// Saturating 8-bit count of rocket/asteroid overlap pixels; clear has priority.
module overlap_counter
  import galaga_pkg::*;
(
  input  logic       vgaclk,
  input  logic       reset_b,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] count
);

  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b)                      count <= 8'd0;
    else if (clr)                      count <= 8'd0;
    else if (inc && count != 8'hFF)    count <= count + 8'd1;
  end

endmodule

// File: rtl/collision_monitor.sv
// Per-frame collision evaluation and game state machine driving lives/score/freeze/flash.
module collision_monitor
  import galaga_pkg::*;
#(
  parameter int LIVES      = LIVES_DEF,
  parameter int HITMIN     = HITMIN_DEF,
  parameter int HIT_FRAMES = HIT_FRAMES_DEF
) (
  input  logic                vgaclk,
  input  logic                reset_b,
  collision_monitor_if.slave  bus
);

  logic        vsync_q;
  logic        armed_q;
  logic        frame_end;
  logic [7:0]  overlap;
  logic        collide;

  game_state_t state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  timer_q, timer_d;
  logic        freeze_q, freeze_d;
  logic        hit_q, hit_d;
  logic        flash;

  // armed_q blocks a frame_end until vsync has been seen high since reset,
  // so vsync held low across reset release cannot fake a falling edge.
  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      vsync_q <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      vsync_q <= bus.vsync;
      armed_q <= armed_q | bus.vsync;
    end
  end

  assign frame_end = armed_q & vsync_q & ~bus.vsync;
  assign collide   = (overlap >= 8'(HITMIN));

  overlap_counter u_overlap (
    .vgaclk  (vgaclk),
    .reset_b (reset_b),
    .inc     (bus.blank_b & bus.rpixel & bus.apixel),
    .clr     (frame_end),
    .count   (overlap)
  );

  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= IDLE;
      lives_q  <= 3'(LIVES);
      score_q  <= 16'd0;
      timer_q  <= 8'd0;
      freeze_q <= 1'b1;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      timer_q  <= timer_d;
      freeze_q <= freeze_d;
      hit_q    <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    timer_d = timer_q;
    hit_d   = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        IDLE, OVER: begin
          if (bus.start) begin
            state_d = PLAY;
            lives_d = 3'(LIVES);
            score_d = 16'd0;
          end
        end
        PLAY: begin
          if (collide) begin
            hit_d = 1'b1;
            if (lives_q <= 3'd1) begin
              lives_d = 3'd0;
              state_d = OVER;
            end else begin
              lives_d = lives_q - 3'd1;
              timer_d = 8'(HIT_FRAMES);
              state_d = HIT;
            end
          end else begin
            score_d = sat_inc16(score_q);
          end
        end
        HIT: begin
          score_d = sat_inc16(score_q);
          if (timer_q <= 8'd1) begin
            timer_d = 8'd0;
            state_d = PLAY;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    freeze_d = (state_d == IDLE) || (state_d == OVER);
  end

  always_comb begin
    flash     = (state_q == HIT) & timer_q[3];
    bus.state  = state_q;
    bus.lives  = lives_q;
    bus.score  = score_q;
    bus.freeze = freeze_q;
    bus.flash  = flash;
    bus.hit    = hit_q;
  end

endmodule

// File: tb/tb_collision_monitor.sv
// Directed bench for collision_monitor: frames are built from visible, blanking and vsync-low spans.
module tb_collision_monitor;
  import galaga_pkg::*;

  logic vgaclk = 1'b0;
  logic reset_b;
  always #5 vgaclk = ~vgaclk;

  collision_monitor_if bus ();

  collision_monitor #(.LIVES(3), .HITMIN(4), .HIT_FRAMES(60)) dut (
    .vgaclk  (vgaclk),
    .reset_b (reset_b),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int hit_total = 0;
  logic [15:0] exp_score;
  logic [0:0]  exp_q[$];

  always @(negedge vgaclk) if (bus.hit === 1'b1) hit_total++;

  // Starts on a negedge; ends 3 negedges after vsync falls (evaluation visible).
  task automatic frame(input int n_vis, input int n_blank, input logic st);
    bus.vsync = 1'b1; bus.blank_b = 1'b1; bus.start = st;
    for (int i = 0; i < n_vis + 4; i++) begin
      bus.rpixel = (i < n_vis); bus.apixel = (i < n_vis);
      @(negedge vgaclk);
    end
    bus.blank_b = 1'b0;
    for (int i = 0; i < n_blank + 2; i++) begin
      bus.rpixel = (i < n_blank); bus.apixel = (i < n_blank);
      @(negedge vgaclk);
    end
    bus.rpixel = 1'b0; bus.apixel = 1'b0; bus.vsync = 1'b0;
    repeat (3) @(negedge vgaclk);
  endtask

  task automatic test_reset;
    reset_b = 1'b0;
    bus.vsync = 1'b1; bus.blank_b = 1'b0; bus.rpixel = 1'b0; bus.apixel = 1'b0; bus.start = 1'b0;
    repeat (3) @(negedge vgaclk);
    reset_b = 1'b1;
    @(negedge vgaclk);
    n_checks++; if (bus.state !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", bus.state, IDLE); else n_pass++;
    n_checks++; if (bus.lives !== 3'd3) $display("FAIL reset_lives got=%0d exp=3", bus.lives); else n_pass++;
    n_checks++; if (bus.score !== 16'd0) $display("FAIL reset_score got=%0d exp=0", bus.score); else n_pass++;
    n_checks++; if (bus.freeze !== 1'b1) $display("FAIL reset_freeze got=%b exp=1", bus.freeze); else n_pass++;
    n_checks++; if ({bus.flash, bus.hit} !== 2'b00) $display("FAIL reset_flash_hit got=%b exp=00", {bus.flash, bus.hit}); else n_pass++;
    repeat (2) frame(0, 0, 1'b0);
    n_checks++; if (bus.state !== IDLE) $display("FAIL idle_hold_state got=%0d exp=%0d", bus.state, IDLE); else n_pass++;
    n_checks++; if ({bus.freeze, bus.lives, bus.score} !== {1'b1, 3'd3, 16'd0}) $display("FAIL idle_hold_outs got=%b/%0d/%0d exp=1/3/0", bus.freeze, bus.lives, bus.score); else n_pass++;
    frame(0, 0, 1'b1);
    n_checks++; if (bus.state !== PLAY) $display("FAIL start_state got=%0d exp=%0d", bus.state, PLAY); else n_pass++;
    n_checks++; if (bus.freeze !== 1'b0) $display("FAIL start_freeze got=%b exp=0", bus.freeze); else n_pass++;
    exp_score = 16'd0;
  endtask

  task automatic test_score;
    int h0;
    h0 = hit_total;
    // start held high in PLAY must not restart the game
    for (int f = 0; f < 10; f++) frame(0, 0, 1'b1);
    n_checks++; if (bus.score !== 16'd10) $display("FAIL score_10 got=%0d exp=10", bus.score); else n_pass++;
    n_checks++; if (hit_total !== h0) $display("FAIL score_no_hit got=%0d exp=%0d", hit_total, h0); else n_pass++;
    n_checks++; if (bus.state !== PLAY) $display("FAIL score_state got=%0d exp=%0d", bus.state, PLAY); else n_pass++;
    exp_score = 16'd10;
  endtask

  task automatic test_threshold;
    int h0;
    h0 = hit_total;
    frame(3, 0, 1'b0);
    exp_score = exp_score + 16'd1;
    n_checks++; if (hit_total !== h0) $display("FAIL thr3_hit got=%0d exp=%0d", hit_total, h0); else n_pass++;
    n_checks++; if (bus.score !== exp_score) $display("FAIL thr3_score got=%0d exp=%0d", bus.score, exp_score); else n_pass++;
    frame(4, 0, 1'b0);
    n_checks++; if (hit_total !== h0 + 1) $display("FAIL thr4_hit_pulse got=%0d exp=%0d", hit_total - h0, 1); else n_pass++;
    n_checks++; if (bus.lives !== 3'd2) $display("FAIL thr4_lives got=%0d exp=2", bus.lives); else n_pass++;
    n_checks++; if (bus.state !== HIT) $display("FAIL thr4_state got=%0d exp=%0d", bus.state, HIT); else n_pass++;
    n_checks++; if (dut.timer_q !== 8'd60) $display("FAIL thr4_timer got=%0d exp=60", dut.timer_q); else n_pass++;
    n_checks++; if (bus.score !== exp_score) $display("FAIL thr4_score got=%0d exp=%0d", bus.score, exp_score); else n_pass++;
  endtask

  task automatic test_invulnerable;
    logic [7:0] exp_timer;
    logic [0:0] exp_flash;
    int h0;
    h0 = hit_total;
    for (int f = 1; f <= 60; f++) begin
      frame(100, 0, 1'b0);
      exp_timer = 8'(60 - f);
      exp_score = sat_inc16(exp_score);
      exp_q.push_back((f < 60) ? exp_timer[3] : 1'b0);
      exp_flash = exp_q.pop_front();
      n_checks++; if (bus.lives !== 3'd2) $display("FAIL inv_lives f=%0d got=%0d exp=2", f, bus.lives); else n_pass++;
      n_checks++; if (bus.score !== exp_score) $display("FAIL inv_score f=%0d got=%0d exp=%0d", f, bus.score, exp_score); else n_pass++;
      n_checks++; if (bus.flash !== exp_flash) $display("FAIL inv_flash f=%0d got=%b exp=%b", f, bus.flash, exp_flash); else n_pass++;
      n_checks++; if (bus.state !== ((f < 60) ? HIT : PLAY)) $display("FAIL inv_state f=%0d got=%0d", f, bus.state); else n_pass++;
    end
    n_checks++; if (hit_total !== h0) $display("FAIL inv_no_hit got=%0d exp=%0d", hit_total, h0); else n_pass++;
  endtask

  task automatic test_saturation;
    force dut.score_q = 16'hFFFE;
    #1;
    release dut.score_q;
    frame(0, 0, 1'b0);
    n_checks++; if (bus.score !== 16'hFFFF) $display("FAIL sat_first got=%h exp=ffff", bus.score); else n_pass++;
    repeat (2) frame(0, 0, 1'b0);
    n_checks++; if (bus.score !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", bus.score); else n_pass++;
  endtask

  task automatic test_game_over;
    int h0;
    frame(8, 0, 1'b0);
    n_checks++; if ({bus.state, bus.lives} !== {HIT, 3'd1}) $display("FAIL go_second_hit got=%0d/%0d exp=%0d/1", bus.state, bus.lives, HIT); else n_pass++;
    for (int f = 0; f < 60; f++) frame(0, 0, 1'b0);
    n_checks++; if (bus.state !== PLAY) $display("FAIL go_back_play got=%0d exp=%0d", bus.state, PLAY); else n_pass++;
    h0 = hit_total;
    frame(0, 10, 1'b0);
    n_checks++; if (hit_total !== h0) $display("FAIL go_blank_ignored got=%0d exp=%0d", hit_total, h0); else n_pass++;
    n_checks++; if ({bus.state, bus.lives} !== {PLAY, 3'd1}) $display("FAIL go_blank_state got=%0d/%0d exp=%0d/1", bus.state, bus.lives, PLAY); else n_pass++;
    frame(5, 0, 1'b0);
    n_checks++; if (hit_total !== h0 + 1) $display("FAIL go_hit_pulse got=%0d exp=1", hit_total - h0); else n_pass++;
    n_checks++; if ({bus.state, bus.lives, bus.freeze} !== {OVER, 3'd0, 1'b1}) $display("FAIL go_over got=%0d/%0d/%b exp=%0d/0/1", bus.state, bus.lives, bus.freeze, OVER); else n_pass++;
    frame(6, 0, 1'b0);
    n_checks++; if ({bus.state, bus.lives, bus.score} !== {OVER, 3'd0, 16'hFFFF}) $display("FAIL go_frozen got=%0d/%0d/%h exp=%0d/0/ffff", bus.state, bus.lives, bus.score, OVER); else n_pass++;
    frame(0, 0, 1'b1);
    n_checks++; if ({bus.state, bus.lives, bus.score, bus.freeze} !== {PLAY, 3'd3, 16'd0, 1'b0}) $display("FAIL go_restart got=%0d/%0d/%0d/%b exp=%0d/3/0/0", bus.state, bus.lives, bus.score, bus.freeze, PLAY); else n_pass++;
  endtask

  task automatic test_mid_reset;
    int h0;
    bus.vsync = 1'b1; bus.blank_b = 1'b1; bus.start = 1'b1;
    bus.rpixel = 1'b1; bus.apixel = 1'b1;
    repeat (10) @(negedge vgaclk);
    n_checks++; if (dut.u_overlap.count !== 8'd10) $display("FAIL mr_accum got=%0d exp=10", dut.u_overlap.count); else n_pass++;
    reset_b = 1'b0; bus.rpixel = 1'b0; bus.apixel = 1'b0;
    @(negedge vgaclk);
    bus.vsync = 1'b0;
    repeat (2) @(negedge vgaclk);
    reset_b = 1'b1;
    @(negedge vgaclk);
    h0 = hit_total;
    n_checks++; if (dut.u_overlap.count !== 8'd0) $display("FAIL mr_overlap got=%0d exp=0", dut.u_overlap.count); else n_pass++;
    n_checks++; if ({bus.state, bus.lives, bus.score} !== {IDLE, 3'd3, 16'd0}) $display("FAIL mr_outs got=%0d/%0d/%0d exp=0/3/0", bus.state, bus.lives, bus.score); else n_pass++;
    n_checks++; if ({bus.freeze, bus.flash, bus.hit} !== 3'b100) $display("FAIL mr_flags got=%b exp=100", {bus.freeze, bus.flash, bus.hit}); else n_pass++;
    repeat (5) @(negedge vgaclk);
    n_checks++; if (bus.state !== IDLE) $display("FAIL mr_no_false_edge got=%0d exp=%0d", bus.state, IDLE); else n_pass++;
    bus.vsync = 1'b1;
    repeat (3) @(negedge vgaclk);
    bus.vsync = 1'b0;
    @(negedge vgaclk);
    n_checks++; if ({bus.state, bus.freeze} !== {PLAY, 1'b0}) $display("FAIL mr_first_eval got=%0d/%b exp=%0d/0", bus.state, bus.freeze, PLAY); else n_pass++;
    n_checks++; if (hit_total !== h0) $display("FAIL mr_no_hit got=%0d exp=%0d", hit_total, h0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_score();
    test_threshold();
    test_invulnerable();
    test_saturation();
    test_game_over();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
